addsub48: RTL and testbench

// - Registered 48-bit two's-complement adder/subtractor modelled on the DSP48E
//   ALU add/sub mode. Used as a datapath primitive in DSP48E application blocks

---
 rtl/addsub48_pkg.sv | 8 +
 rtl/addsub_core.sv | 22 ++
 rtl/addsub48.sv | 45 ++++
 tb/tb_addsub48.sv | 120 ++++++++++++
 4 files changed

// File: rtl/addsub48_pkg.sv
// Shared definitions for the 48-bit registered adder/subtractor.
//   ADDSUB_W : operand/result width
//   OP_ADD / OP_SUB : encodings of the ADD_SUB select
package addsub48_pkg;
    localparam int   ADDSUB_W = 48;
    localparam logic OP_ADD   = 1'b0;
    localparam logic OP_SUB   = 1'b1;
endpackage

// File: rtl/addsub_core.sv
// Combinational WIDTH-bit add/subtract.
//   a, c : operands
//   op   : OP_ADD -> a + c, OP_SUB -> a - c
//   sum  : result modulo 2^WIDTH
module addsub_core
    import addsub48_pkg::*;
#(
    parameter int WIDTH = ADDSUB_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] c,
    input  logic             op,
    output logic [WIDTH-1:0] sum
);
    logic [WIDTH-1:0] c_eff;
    logic [WIDTH-1:0] cin;

    // Subtract as a + ~c + 1: the invert and the carry-in share the op bit.
    assign c_eff = (op == OP_SUB) ? ~c : c;
    assign cin   = {{(WIDTH-1){1'b0}}, op};
    assign sum   = a + c_eff + cin;
endmodule

// File: rtl/addsub48.sv
// Registered 48-bit two's-complement adder/subtractor, two-cycle latency,
// one result per clock.
//   CLK          : clock, rising edge
//   RST          : synchronous active-high reset, clears all registers
//   A_IN, C_IN   : operands (A - C when subtracting)
//   ADD_SUB      : 0 add, 1 subtract; captured alongside the operands
//   ADDSUB48_OUT : registered result modulo 2^48
module addsub48
    import addsub48_pkg::*;
#(
    parameter int WIDTH = ADDSUB_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A_IN,
    input  logic [WIDTH-1:0] C_IN,
    input  logic             ADD_SUB,
    output logic [WIDTH-1:0] ADDSUB48_OUT
);
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] c_r;
    logic             op_r;
    logic [WIDTH-1:0] sum;

    addsub_core #(.WIDTH(WIDTH)) u_core (
        .a   (a_r),
        .c   (c_r),
        .op  (op_r),
        .sum (sum)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            a_r          <= '0;
            c_r          <= '0;
            op_r         <= OP_ADD;
            ADDSUB48_OUT <= '0;
        end else begin
            a_r          <= A_IN;
            c_r          <= C_IN;
            op_r         <= ADD_SUB;
            ADDSUB48_OUT <= sum;
        end
    end
endmodule

// File: tb/tb_addsub48.sv
module tb_addsub48;
    localparam int W = 48;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] c_in = '0;
    logic         add_sub = 1'b0;
    logic [W-1:0] out;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference pipeline: value due on OUT after the next edge, and current value.
    logic [W-1:0] ref_pend = '0;
    logic [W-1:0] ref_out  = '0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] c;
        logic         op;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    addsub48 dut (
        .CLK          (clk),
        .RST          (rst),
        .A_IN         (a_in),
        .C_IN         (c_in),
        .ADD_SUB      (add_sub),
        .ADDSUB48_OUT (out)
    );

    function automatic logic [W-1:0] arith(input logic [W-1:0] a, input logic [W-1:0] c,
                                           input logic op);
        return op ? W'(a - c) : W'(a + c);
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: drive on the falling edge, let the rising edge capture,
    // advance the reference, then settle before sampling.
    task automatic step(input logic r, input logic [W-1:0] a, input logic [W-1:0] c,
                        input logic op);
        @(negedge clk);
        rst = r; a_in = a; c_in = c; add_sub = op;
        @(posedge clk);
        if (r) begin
            ref_out  = '0;
            ref_pend = '0;
        end else begin
            ref_out  = ref_pend;
            ref_pend = arith(a, c, op);
        end
        #1;
        check("model", out, ref_out);
    endtask

    initial begin
        vecs[0] = '{48'd512, 48'd512, 1'b0, 48'h0000_0000_0400};
        vecs[1] = '{48'd2020, 48'd2020, 1'b0, 48'h0000_0000_0FC8};
        vecs[2] = '{48'd1110, 48'd10, 1'b1, 48'h0000_0000_044C};
        vecs[3] = '{48'd1110, 48'd1115, 1'b1, 48'hFFFF_FFFF_FFFB};
        vecs[4] = '{48'hFFFF_FFFF_FFFF, 48'd1, 1'b0, 48'h0};
        vecs[5] = '{48'h0, 48'd1, 1'b1, 48'hFFFF_FFFF_FFFF};
        vecs[6] = '{48'h8000_0000_0000, 48'h8000_0000_0000, 1'b0, 48'h0};
        vecs[7] = '{48'h1234_5678_9ABC, 48'h1234_5678_9ABC, 1'b1, 48'h0};

        // Reset with arbitrary inputs: OUT held at 0.
        for (int i = 0; i < 2; i++) begin
            step(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
            check("reset_out", out, '0);
        end
        // First post-reset edge still shows the cleared pipeline.
        step(1'b0, vecs[0].a, vecs[0].c, vecs[0].op);
        check("post_reset_zero", out, '0);
        for (int i = 1; i < 8; i++) begin
            step(1'b0, vecs[i].a, vecs[i].c, vecs[i].op);
            check($sformatf("vec%0d", i - 1), out, vecs[i-1].exp);
        end
        step(1'b0, '0, '0, 1'b0);
        check("vec7", out, vecs[7].exp);

        // Back-to-back with op toggling each cycle: 130 / 70 two cycles later.
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 48'd100, 48'd30, 1'(i & 1));
            if (i >= 1) check("toggle", out, ((i - 1) & 1) ? 48'd70 : 48'd130);
        end
        // Mid-stream reset: in-flight results lost, stream resumes.
        step(1'b1, 48'd100, 48'd30, 1'b0);
        check("mid_rst", out, '0);
        step(1'b0, 48'd100, 48'd30, 1'b1);
        check("mid_rst_flush", out, '0);
        step(1'b0, 48'd100, 48'd30, 1'b0);
        check("resume_sub", out, 48'd70);
        step(1'b0, 48'd100, 48'd30, 1'b1);
        check("resume_add", out, 48'd130);
        step(1'b0, 48'd0, 48'd0, 1'b0);
        check("resume_sub2", out, 48'd70);

        // Randomized stream with occasional resets, checked against the model.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 31) == 0), {$urandom, $urandom}, {$urandom, $urandom},
                 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
